// File: rtl/vco_adc_seq_ctrl.sv
// Conversion sequencer for the VCO-based ADC. It powers the VCO and waits for
// it to settle. It then counts VCO edges over back-to-back windows and sums N
// window counts into one result. The result goes to the register logic over
// a valid/ready handshake. Single-shot and continuous modes are supported.
module vco_adc_seq_ctrl #(
  parameter int CNT_W = 16,
  parameter int WIN_W = 16,
  parameter int SET_W = 12,
  parameter int NUM_W = 8,
  parameter int ACC_W = 24
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             start,
  input  logic             cont,
  input  logic             abort,
  input  logic [SET_W-1:0] cfg_settle,
  input  logic [WIN_W-1:0] cfg_win,
  input  logic [NUM_W-1:0] cfg_num,
  input  logic [CNT_W-1:0] vco_cnt,
  output logic             vco_en,
  output logic             busy,
  output logic [ACC_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ready
);

  typedef enum logic [1:0] {IDLE, SETTLE, WINDOW, OUTPUT} state_t;

  state_t           state_q;
  logic [SET_W-1:0] scnt_q;
  logic [WIN_W-1:0] wcnt_q;
  logic [WIN_W-1:0] win_q;
  logic [NUM_W-1:0] num_q;
  logic [NUM_W-1:0] nsamp_q;
  logic [CNT_W-1:0] base_q;
  logic [ACC_W-1:0] acc_q;
  logic             cont_q;
  logic             vco_en_q;
  logic             busy_q;
  logic [ACC_W-1:0] result_q;
  logic             valid_q;

  // Modular subtraction absorbs a single counter wrap inside one window
  logic [CNT_W-1:0] diff_d;
  logic [ACC_W-1:0] acc_d;
  logic             last_d;

  assign diff_d = vco_cnt - base_q;
  assign acc_d  = acc_q + {{(ACC_W-CNT_W){1'b0}}, diff_d};
  assign last_d = ({1'b0, nsamp_q} + (NUM_W+1)'(1)) == {1'b0, num_q};

  // Sequencer FSM; all outputs are registered alongside the state
  always_ff @(posedge clock) begin
    if (!resetb) begin
      state_q  <= IDLE;
      scnt_q   <= '0;
      wcnt_q   <= '0;
      win_q    <= '0;
      num_q    <= '0;
      nsamp_q  <= '0;
      base_q   <= '0;
      acc_q    <= '0;
      cont_q   <= 1'b0;
      vco_en_q <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else if (abort && state_q != IDLE) begin
      // Drop everything, including any result not yet taken
      state_q  <= IDLE;
      vco_en_q <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            win_q    <= (cfg_win == '0) ? WIN_W'(1) : cfg_win;
            num_q    <= (cfg_num == '0) ? NUM_W'(1) : cfg_num;
            cont_q   <= cont;
            scnt_q   <= cfg_settle;
            vco_en_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= SETTLE;
          end
        end
        SETTLE: begin
          if (scnt_q == '0) begin
            base_q  <= vco_cnt;
            acc_q   <= '0;
            nsamp_q <= '0;
            wcnt_q  <= win_q - WIN_W'(1);
            state_q <= WINDOW;
          end else begin
            scnt_q <= scnt_q - SET_W'(1);
          end
        end
        WINDOW: begin
          if (wcnt_q == '0) begin
            // The capture sample also becomes the next base, so windows abut
            acc_q   <= acc_d;
            base_q  <= vco_cnt;
            nsamp_q <= nsamp_q + NUM_W'(1);
            wcnt_q  <= win_q - WIN_W'(1);
            if (last_d) begin
              result_q <= acc_d;
              valid_q  <= 1'b1;
              state_q  <= OUTPUT;
            end
          end else begin
            wcnt_q <= wcnt_q - WIN_W'(1);
          end
        end
        OUTPUT: begin
          // Windows stay frozen while the consumer stalls
          if (result_ready) begin
            valid_q <= 1'b0;
            if (cont_q) begin
              acc_q   <= '0;
              nsamp_q <= '0;
              base_q  <= vco_cnt;
              wcnt_q  <= win_q - WIN_W'(1);
              state_q <= WINDOW;
            end else begin
              vco_en_q <= 1'b0;
              busy_q   <= 1'b0;
              state_q  <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign vco_en       = vco_en_q;
  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_vco_adc_seq_ctrl.sv
// Directed bench for the VCO ADC sequencer. It covers latency and result
// value, counter wrap, backpressure, continuous mode, abort, zero configs
// and mid-run reset.
module tb_vco_adc_seq_ctrl;

  logic        clock = 1'b0;
  logic        resetb, start, cont, abort, result_ready;
  logic [11:0] cfg_settle;
  logic [15:0] cfg_win;
  logic [7:0]  cfg_num;
  logic [15:0] vco_cnt = 16'h0123;
  logic [15:0] vco_step = 16'd1;
  logic        vco_load = 1'b0;
  logic        vco_en, busy, result_valid;
  logic [23:0] result;

  int cmp = 0;
  int err = 0;

  vco_adc_seq_ctrl dut (
    .clock(clock), .resetb(resetb), .start(start), .cont(cont), .abort(abort),
    .cfg_settle(cfg_settle), .cfg_win(cfg_win), .cfg_num(cfg_num),
    .vco_cnt(vco_cnt), .vco_en(vco_en), .busy(busy), .result(result),
    .result_valid(result_valid), .result_ready(result_ready)
  );

  always #5 clock = ~clock;

  // Free-running VCO edge counter model, optionally preset near wrap
  always @(posedge clock) vco_cnt <= vco_load ? 16'hFFF0 : vco_cnt + vco_step;

  // Arms a conversion on the current negedge; caller then waits
  task automatic kick(input logic [11:0] s, input logic [15:0] w,
                      input logic [7:0] n, input logic c);
    @(negedge clock);
    cfg_settle = s; cfg_win = w; cfg_num = n; cont = c; start = 1'b1;
  endtask

  // Waits for result_valid; lat = index of edge after start (0 = start edge)
  task automatic wait_valid(input int bound, output int lat);
    lat = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clock);
      if (i == 0) begin start = 1'b0; vco_load = 1'b0; end
      if (result_valid) begin lat = i; break; end
    end
  endtask

  task automatic test_reset();
    resetb = 1'b0; start = 1'b0; cont = 1'b0; abort = 1'b0; result_ready = 1'b0;
    cfg_settle = '0; cfg_win = '0; cfg_num = '0;
    repeat (3) @(negedge clock);
    cmp++;
    if ({vco_en, busy, result_valid, result} !== 27'd0) begin
      err++; $display("FAIL reset_outputs got %h want 0", {vco_en, busy, result_valid, result});
    end
    resetb = 1'b1;
    @(negedge clock);
    cmp++;
    if (busy !== 1'b0) begin err++; $display("FAIL reset_idle busy got %b want 0", busy); end
  endtask

  // Also pulses start mid-run with different cfg, which must be ignored
  task automatic test_single_shot();
    int lat;
    kick(12'd5, 16'd100, 8'd4, 1'b0);
    lat = -1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (i == 0) begin
        start = 1'b0;
        cmp++;
        if ({vco_en, busy} !== 2'b11) begin
          err++; $display("FAIL start_en got %b want 11", {vco_en, busy});
        end
      end
      if (i == 100) begin start = 1'b1; cfg_win = 16'd7; cfg_num = 8'd1; end
      if (i == 101) start = 1'b0;
      if (result_valid) begin lat = i; break; end
    end
    cmp++;
    if (lat != 406) begin err++; $display("FAIL single_latency got %0d want 406", lat); end
    cmp++;
    if (result !== 24'd400) begin err++; $display("FAIL single_result got %0d want 400", result); end
    result_ready = 1'b1;
    @(negedge clock);
    result_ready = 1'b0;
    cmp++;
    if ({result_valid, busy, vco_en} !== 3'b000) begin
      err++; $display("FAIL single_done got %b want 000", {result_valid, busy, vco_en});
    end
  endtask

  task automatic test_wrap();
    int lat;
    vco_step = 16'd3;
    kick(12'd0, 16'd16, 8'd1, 1'b0);
    vco_load = 1'b1;
    wait_valid(200, lat);
    cmp++;
    if (lat != 17) begin err++; $display("FAIL wrap_latency got %0d want 17", lat); end
    cmp++;
    if (result !== 24'd48) begin err++; $display("FAIL wrap_result got %0d want 48", result); end
    result_ready = 1'b1;
    @(negedge clock);
    result_ready = 1'b0;
    vco_step = 16'd1;
  endtask

  task automatic test_backpressure();
    int lat;
    int bad = 0;
    int hs = 0;
    kick(12'd0, 16'd8, 8'd1, 1'b0);
    wait_valid(100, lat);
    cmp++;
    if (result !== 24'd8) begin err++; $display("FAIL bp_result got %0d want 8", result); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (result_valid !== 1'b1 || result !== 24'd8 || busy !== 1'b1) bad++;
    end
    cmp++;
    if (bad != 0) begin err++; $display("FAIL bp_stable got %0d unstable cycles want 0", bad); end
    result_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (result_valid) hs++;
    end
    result_ready = 1'b0;
    cmp++;
    if (hs != 0 || busy !== 1'b0) begin
      err++; $display("FAIL bp_one_handshake got valid_after=%0d busy=%b want 0/0", hs, busy);
    end
  endtask

  task automatic test_back_to_back();
    int nres = 0;
    int badres = 0;
    int endrop = 0;
    result_ready = 1'b1;
    kick(12'd2, 16'd10, 8'd2, 1'b1);
    // Valid expected after edges 23, 44, 65, 86
    for (int i = 0; i < 90; i++) begin
      @(negedge clock);
      if (i == 0) start = 1'b0;
      if (vco_en !== 1'b1) endrop++;
      if (result_valid) begin
        nres++;
        if (result !== 24'd20) badres++;
      end
    end
    cmp++;
    if (nres != 4) begin err++; $display("FAIL cont_count got %0d want 4", nres); end
    cmp++;
    if (badres != 0) begin err++; $display("FAIL cont_result got %0d bad want 0", badres); end
    cmp++;
    if (endrop != 0) begin err++; $display("FAIL cont_vco_en got %0d drops want 0", endrop); end
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    result_ready = 1'b0;
    cmp++;
    if ({busy, vco_en} !== 2'b00) begin
      err++; $display("FAIL cont_abort got %b want 00", {busy, vco_en});
    end
  endtask

  task automatic test_abort();
    int seen = 0;
    kick(12'd1, 16'd50, 8'd2, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (i == 0) start = 1'b0;
    end
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    cmp++;
    if ({busy, vco_en, result_valid} !== 3'b000) begin
      err++; $display("FAIL abort_idle got %b want 000", {busy, vco_en, result_valid});
    end
    for (int i = 0; i < 150; i++) begin
      @(negedge clock);
      if (result_valid || busy) seen++;
    end
    cmp++;
    if (seen != 0) begin err++; $display("FAIL abort_no_result got %0d want 0", seen); end
  endtask

  task automatic test_zero_cfg_and_reset();
    int lat;
    kick(12'd0, 16'd0, 8'd0, 1'b0);
    wait_valid(50, lat);
    cmp++;
    if (lat != 2) begin err++; $display("FAIL zero_latency got %0d want 2", lat); end
    cmp++;
    if (result !== 24'd1) begin err++; $display("FAIL zero_result got %0d want 1", result); end
    // Reset while the result is still pending
    resetb = 1'b0;
    @(negedge clock);
    resetb = 1'b1;
    cmp++;
    if ({vco_en, busy, result_valid, result} !== 27'd0) begin
      err++; $display("FAIL midrun_reset got %h want 0", {vco_en, busy, result_valid, result});
    end
    kick(12'd3, 16'd40, 8'd2, 1'b0);
    repeat (10) @(negedge clock);
    start = 1'b0;
    resetb = 1'b0;
    @(negedge clock);
    resetb = 1'b1;
    cmp++;
    if ({vco_en, busy, result_valid} !== 3'b000) begin
      err++; $display("FAIL window_reset got %b want 000", {vco_en, busy, result_valid});
    end
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_zero_cfg_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule
